// File: rtl/regbus_pkg.sv
// regbus_pkg: shared widths, FSM state encoding and a requester-id helper
// for the register-bus arbiter.
package regbus_pkg;

    localparam int REGBUS_ADDR_W = 8;
    localparam int REGBUS_DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_DONE   = 2'd3
    } regbus_state_t;

    // Requester id (0/1) to its one-hot position.
    function automatic logic [1:0] regbus_onehot(input logic id);
        return id ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/regbus_grant.sv
// regbus_grant: two-way grant selection. The grant is one-hot and only ever
// names a requester whose valid is high.
// Round-robin on simultaneous requests when REGBUS_ARBITER_RR_EN is defined,
// otherwise requester 0 has fixed priority.
module regbus_grant
    import regbus_pkg::*;
(
    input  logic [1:0] i_valid,
    input  logic       i_last_grant,
    output logic [1:0] o_grant
);

`ifdef REGBUS_ARBITER_RR_EN
    // Ties go to the requester that did not win last time.
    always_comb begin
        o_grant = i_valid;
        if (i_valid == 2'b11) begin
            o_grant = regbus_onehot(~i_last_grant);
        end
    end
`else
    logic w_unused_last_grant;
    assign w_unused_last_grant = i_last_grant;

    // Requester 0 always wins a tie.
    always_comb begin
        o_grant = 2'b00;
        if (i_valid[0]) begin
            o_grant = 2'b01;
        end else if (i_valid[1]) begin
            o_grant = 2'b10;
        end
    end
`endif

endmodule

// File: rtl/regbus_arbiter.sv
// regbus_arbiter: arbitrates two requesters onto one register bus and runs
// each transfer as SETUP (address/wdata driven) -> STROBE (rd or wr for one
// cycle) -> DONE (completion pulse to the owner).
// Optional feature: define REGBUS_ARBITER_RR_EN for round-robin arbitration.
module regbus_arbiter
    import regbus_pkg::*;
#(
    parameter int unsigned SETUP_CYCLES = 1
) (
    input  logic                     clk,
    input  logic                     nreset,
    input  logic                     req0_valid,
    input  logic                     req0_write,
    input  logic [REGBUS_ADDR_W-1:0] req0_addr,
    input  logic [REGBUS_DATA_W-1:0] req0_wdata,
    output logic                     req0_ready,
    output logic                     req0_done,
    output logic [REGBUS_DATA_W-1:0] req0_rdata,
    input  logic                     req1_valid,
    input  logic                     req1_write,
    input  logic [REGBUS_ADDR_W-1:0] req1_addr,
    input  logic [REGBUS_DATA_W-1:0] req1_wdata,
    output logic                     req1_ready,
    output logic                     req1_done,
    output logic [REGBUS_DATA_W-1:0] req1_rdata,
    output logic [REGBUS_ADDR_W-1:0] address,
    inout  wire  [REGBUS_DATA_W-1:0] data,
    output logic                     rd,
    output logic                     wr,
    output logic                     busy
);

    // Counter preload: SETUP is left when the counter reaches zero, so load
    // one less than the number of setup cycles.
    localparam logic [3:0] SETUP_LOAD = (SETUP_CYCLES == 0) ? 4'd0 : 4'(SETUP_CYCLES - 1);

    regbus_state_t            r_state;
    regbus_state_t            w_state_next;
    logic [3:0]               r_cnt;
    logic [REGBUS_ADDR_W-1:0] r_addr;
    logic [REGBUS_DATA_W-1:0] r_wdata;
    logic                     r_write;
    logic                     r_id;
    logic [REGBUS_DATA_W-1:0] r_rdata0;
    logic [REGBUS_DATA_W-1:0] r_rdata1;
    logic                     w_last_grant;
    logic [1:0]               w_grant;
    logic [1:0]               w_ready;
    logic [1:0]               w_done;
    logic                     w_accept;
    logic                     w_sel;
    logic                     w_rd;
    logic                     w_wr;
    logic                     w_drive;

    regbus_grant u_grant (
        .i_valid      ({req1_valid, req0_valid}),
        .i_last_grant (w_last_grant),
        .o_grant      (w_grant)
    );

    assign w_accept = |w_ready;
    assign w_sel    = w_grant[1];

`ifdef REGBUS_ARBITER_RR_EN
    logic r_last_grant;

    // Remember which requester won the most recent accept.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_last_grant <= 1'b1;
        end else if (w_accept) begin
            r_last_grant <= w_sel;
        end
    end

    assign w_last_grant = r_last_grant;
`else
    assign w_last_grant = 1'b1;
`endif

    // State register.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; SETUP is skipped entirely when no setup is configured.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:   if (w_accept) w_state_next = (SETUP_CYCLES == 0) ? ST_STROBE : ST_SETUP;
            ST_SETUP:  if (r_cnt == 4'd0) w_state_next = ST_STROBE;
            ST_STROBE: w_state_next = ST_DONE;
            ST_DONE:   w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    // FSM outputs; ready is also held low while reset is asserted.
    always_comb begin
        w_ready = 2'b00;
        w_done  = 2'b00;
        w_rd    = 1'b0;
        w_wr    = 1'b0;
        w_drive = 1'b0;
        case (r_state)
            ST_IDLE:   w_ready = nreset ? w_grant : 2'b00;
            ST_SETUP:  w_drive = r_write;
            ST_STROBE: begin
                w_drive = r_write;
                w_rd    = ~r_write;
                w_wr    = r_write;
            end
            ST_DONE:   w_done = regbus_onehot(r_id);
            default:   w_ready = 2'b00;
        endcase
    end

    // Transaction latch, setup counter and read capture. The address register
    // is only reloaded on accept, so the bus address is stable while idle.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_cnt    <= 4'd0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_write  <= 1'b0;
            r_id     <= 1'b0;
            r_rdata0 <= '0;
            r_rdata1 <= '0;
        end else begin
            if (w_accept) begin
                r_cnt   <= SETUP_LOAD;
                r_addr  <= w_sel ? req1_addr  : req0_addr;
                r_wdata <= w_sel ? req1_wdata : req0_wdata;
                r_write <= w_sel ? req1_write : req0_write;
                r_id    <= w_sel;
            end else if (r_state == ST_SETUP && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (r_state == ST_STROBE && !r_write) begin
                if (r_id) begin
                    r_rdata1 <= data;
                end else begin
                    r_rdata0 <= data;
                end
            end
        end
    end

    assign data       = w_drive ? r_wdata : {REGBUS_DATA_W{1'bz}};
    assign address    = r_addr;
    assign rd         = w_rd;
    assign wr         = w_wr;
    assign busy       = (r_state != ST_IDLE);
    assign req0_ready = w_ready[0];
    assign req1_ready = w_ready[1];
    assign req0_done  = w_done[0];
    assign req1_done  = w_done[1];
    assign req0_rdata = r_rdata0;
    assign req1_rdata = r_rdata1;

endmodule

// File: tb/tb_regbus_arbiter.sv
// tb_regbus_arbiter: three arbiter instances (setup 1, 0 and 15 cycles) with
// a register-file read model on each bus, exercised by directed and random
// transactions against a cycle-offset reference model.
`timescale 1ns/1ps
module tb_regbus_arbiter;

    localparam int NI = 3;
    localparam int SETUP_OF [NI] = '{1, 0, 15};

    logic clk = 1'b0;
    logic nreset = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [NI-1:0]      v0, v1, w0, w1;
    logic [NI-1:0][7:0] a0, a1, d0, d1;
    wire  [NI-1:0]      r0, r1, dn0, dn1, rd, wr, busy;
    wire  [NI-1:0][7:0] q0, q1, addr;
    wire  [7:0]         bus0, bus1, bus2;
    logic [NI-1:0]      drv_en;
    logic [NI-1:0][7:0] drv_val;
    logic [7:0]         rmem [NI][256];

    // Reference model state.
    bit         exp_last [NI];
    logic [7:0] exp_rdata [NI][2];
    int total = 0;
    int bad = 0;

    // Register file answering reads while the bench is told to drive.
    assign bus0 = drv_en[0] ? drv_val[0] : 8'hzz;
    assign bus1 = drv_en[1] ? drv_val[1] : 8'hzz;
    assign bus2 = drv_en[2] ? drv_val[2] : 8'hzz;

    regbus_arbiter #(.SETUP_CYCLES(1)) u_dut0 (
        .clk(clk), .nreset(nreset),
        .req0_valid(v0[0]), .req0_write(w0[0]), .req0_addr(a0[0]), .req0_wdata(d0[0]),
        .req0_ready(r0[0]), .req0_done(dn0[0]), .req0_rdata(q0[0]),
        .req1_valid(v1[0]), .req1_write(w1[0]), .req1_addr(a1[0]), .req1_wdata(d1[0]),
        .req1_ready(r1[0]), .req1_done(dn1[0]), .req1_rdata(q1[0]),
        .address(addr[0]), .data(bus0), .rd(rd[0]), .wr(wr[0]), .busy(busy[0])
    );

    regbus_arbiter #(.SETUP_CYCLES(0)) u_dut1 (
        .clk(clk), .nreset(nreset),
        .req0_valid(v0[1]), .req0_write(w0[1]), .req0_addr(a0[1]), .req0_wdata(d0[1]),
        .req0_ready(r0[1]), .req0_done(dn0[1]), .req0_rdata(q0[1]),
        .req1_valid(v1[1]), .req1_write(w1[1]), .req1_addr(a1[1]), .req1_wdata(d1[1]),
        .req1_ready(r1[1]), .req1_done(dn1[1]), .req1_rdata(q1[1]),
        .address(addr[1]), .data(bus1), .rd(rd[1]), .wr(wr[1]), .busy(busy[1])
    );

    regbus_arbiter #(.SETUP_CYCLES(15)) u_dut2 (
        .clk(clk), .nreset(nreset),
        .req0_valid(v0[2]), .req0_write(w0[2]), .req0_addr(a0[2]), .req0_wdata(d0[2]),
        .req0_ready(r0[2]), .req0_done(dn0[2]), .req0_rdata(q0[2]),
        .req1_valid(v1[2]), .req1_write(w1[2]), .req1_addr(a1[2]), .req1_wdata(d1[2]),
        .req1_ready(r1[2]), .req1_done(dn1[2]), .req1_rdata(q1[2]),
        .address(addr[2]), .data(bus2), .rd(rd[2]), .wr(wr[2]), .busy(busy[2])
    );

    function automatic logic [7:0] bus_of(input int k);
        case (k)
            0:       return bus0;
            1:       return bus1;
            default: return bus2;
        endcase
    endfunction

    function automatic logic [1:0] oh(input bit g);
        return g ? 2'b10 : 2'b01;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_req(input int k, input bit r, input bit v, input bit w,
                             input logic [7:0] a, input logic [7:0] d);
        if (r) begin
            v1[k] = v; w1[k] = w; a1[k] = a; d1[k] = d;
        end else begin
            v0[k] = v; w0[k] = w; a0[k] = a; d0[k] = d;
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NI; k++) begin
            exp_last[k]     = 1'b1;
            exp_rdata[k][0] = 8'h00;
            exp_rdata[k][1] = 8'h00;
        end
    endtask

    task automatic clear_inputs();
        v0 = '0; v1 = '0; w0 = '0; w1 = '0;
        a0 = '0; a1 = '0; d0 = '0; d1 = '0;
        drv_en = '0; drv_val = '0;
    endtask

    // One transaction on instance k, starting at a negedge with the instance
    // idle. Expected behaviour by cycle offset c from the accept cycle (c=0):
    // address/wdata for 1..s+1, strobe at s+1, done at s+2, idle at s+3.
    // rst_at > 0 asserts reset at that offset instead of finishing.
    task automatic do_txn(input int k, input bit req, input bit both, input bit wr_en,
                          input logic [7:0] a, input logic [7:0] d, input int rst_at);
        int s;
        bit g;
        logic [7:0] rv;
        s = SETUP_OF[k];
`ifdef REGBUS_ARBITER_RR_EN
        g = both ? ~exp_last[k] : req;
`else
        g = both ? 1'b0 : req;
`endif
        rv = rmem[k][a];
        drive_req(k, g, 1'b1, wr_en, a, d);
        if (both) drive_req(k, ~g, 1'b1, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
        drv_en[k]  = ~wr_en;
        drv_val[k] = rv;
        #1;
        $display("txn inst=%0d setup=%0d req=%0d both=%0d %s addr=%h wdata=%h t=%0t",
                 k, s, g, both, wr_en ? "write" : "read", a, d, $time);
        check($sformatf("i%0d accept ready", k), 32'({r1[k], r0[k]}), 32'(oh(g)));
        check($sformatf("i%0d accept busy", k), 32'(busy[k]), 32'd0);
        exp_last[k] = g;
        @(posedge clk);
        #1;
        // Winner withdraws and scrambles its inputs; the transfer must not care.
        drive_req(k, g, 1'b0, ~wr_en, 8'($urandom), 8'($urandom));
        for (int c = 1; c <= s + 2; c++) begin
            @(negedge clk);
            if (c == rst_at) begin
                check($sformatf("i%0d rst pre wr", k), 32'(wr[k]), 32'(wr_en));
                nreset = 1'b0;
                #1;
                check($sformatf("i%0d rst wr", k), 32'(wr[k]), 32'd0);
                check($sformatf("i%0d rst rd", k), 32'(rd[k]), 32'd0);
                check($sformatf("i%0d rst busy", k), 32'(busy[k]), 32'd0);
                check($sformatf("i%0d rst addr", k), 32'(addr[k]), 32'd0);
                check($sformatf("i%0d rst done", k), 32'({dn1[k], dn0[k]}), 32'd0);
                model_reset();
                clear_inputs();
                @(negedge clk);
                nreset = 1'b1;
                for (int t = 0; t < s + 3; t++) begin
                    @(negedge clk);
                    check($sformatf("i%0d post-rst done t%0d", k, t), 32'({dn1[k], dn0[k]}), 32'd0);
                    check($sformatf("i%0d post-rst busy t%0d", k, t), 32'(busy[k]), 32'd0);
                end
                return;
            end
            check($sformatf("i%0d c%0d busy", k, c), 32'(busy[k]), 32'd1);
            check($sformatf("i%0d c%0d ready", k, c), 32'({r1[k], r0[k]}), 32'd0);
            if (c <= s + 1) begin
                check($sformatf("i%0d c%0d addr", k, c), 32'(addr[k]), 32'(a));
                check($sformatf("i%0d c%0d data", k, c), 32'(bus_of(k)), 32'(wr_en ? d : rv));
            end
            check($sformatf("i%0d c%0d wr", k, c), 32'(wr[k]), 32'(wr_en && c == s + 1));
            check($sformatf("i%0d c%0d rd", k, c), 32'(rd[k]), 32'(!wr_en && c == s + 1));
            check($sformatf("i%0d c%0d done", k, c), 32'({dn1[k], dn0[k]}),
                  32'((c == s + 2) ? oh(g) : 2'b00));
            if (c == s + 2) begin
                if (!wr_en) exp_rdata[k][g] = rv;
                if (both) drive_req(k, ~g, 1'b0, 1'b0, 8'h00, 8'h00);
            end
            check($sformatf("i%0d c%0d rdata", k, c), 32'(g ? q1[k] : q0[k]), 32'(exp_rdata[k][g]));
        end
        drv_en[k] = 1'b0;
        @(negedge clk);
        check($sformatf("i%0d end busy", k), 32'(busy[k]), 32'd0);
        check($sformatf("i%0d end addr hold", k), 32'(addr[k]), 32'(a));
        check($sformatf("i%0d end done", k), 32'({dn1[k], dn0[k]}), 32'd0);
        check($sformatf("i%0d end rdata0", k), 32'(q0[k]), 32'(exp_rdata[k][0]));
        check($sformatf("i%0d end rdata1", k), 32'(q1[k]), 32'(exp_rdata[k][1]));
    endtask

    // Both requesters valid continuously: check grant order and the
    // accept-to-accept period.
    task automatic arb_run(input int k, input int n);
        int s;
        int last_cyc;
        int t;
        bit g;
        s = SETUP_OF[k];
        last_cyc = 0;
        drive_req(k, 1'b0, 1'b1, 1'b1, 8'h20, 8'hA0);
        drive_req(k, 1'b1, 1'b1, 1'b1, 8'h21, 8'hA1);
        #1;
        for (int i = 0; i < n; i++) begin
            t = 0;
            while (!(r0[k] | r1[k]) && t < s + 6) begin
                @(negedge clk);
                #1;
                t++;
            end
`ifdef REGBUS_ARBITER_RR_EN
            g = ~exp_last[k];
`else
            g = 1'b0;
`endif
            $display("txn inst=%0d arb accept #%0d expect req=%0d cyc=%0d", k, i, g, cyc);
            check($sformatf("i%0d arb%0d grant", k, i), 32'({r1[k], r0[k]}), 32'(oh(g)));
            if (i > 0) check($sformatf("i%0d arb%0d period", k, i), 32'(cyc - last_cyc), 32'(s + 3));
            last_cyc = cyc;
            exp_last[k] = g;
            @(negedge clk);
            #1;
        end
        drive_req(k, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        drive_req(k, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        for (int i = 0; i < s + 4; i++) @(negedge clk);
        check($sformatf("i%0d arb idle", k), 32'(busy[k]), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        model_reset();
        for (int k = 0; k < NI; k++) begin
            for (int i = 0; i < 256; i++) rmem[k][i] = 8'($urandom);
            rmem[k][8'h04] = 8'hC3;
        end
        nreset = 1'b0;
        v0[0] = 1'b1;
        v1[1] = 1'b1;
        repeat (3) @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            check($sformatf("i%0d reset busy", k), 32'(busy[k]), 32'd0);
            check($sformatf("i%0d reset strobes", k), 32'({rd[k], wr[k]}), 32'd0);
            check($sformatf("i%0d reset addr", k), 32'(addr[k]), 32'd0);
            check($sformatf("i%0d reset ready", k), 32'({r1[k], r0[k]}), 32'd0);
            check($sformatf("i%0d reset done", k), 32'({dn1[k], dn0[k]}), 32'd0);
            check($sformatf("i%0d reset rdata", k), 32'({q1[k], q0[k]}), 32'd0);
        end
        clear_inputs();
        nreset = 1'b1;
        @(negedge clk);

        // Directed: write 5A to 10, read C3 from 04, both setup extremes.
        do_txn(0, 1'b0, 1'b0, 1'b1, 8'h10, 8'h5A, -1);
        do_txn(0, 1'b1, 1'b0, 1'b0, 8'h04, 8'h00, -1);
        do_txn(1, 1'b0, 1'b0, 1'b1, 8'h7E, 8'h81, -1);
        do_txn(1, 1'b1, 1'b0, 1'b0, 8'h04, 8'h00, -1);
        do_txn(2, 1'b1, 1'b0, 1'b1, 8'hF0, 8'h0F, -1);
        do_txn(2, 1'b0, 1'b0, 1'b0, 8'h04, 8'h00, -1);

        // Arbitration under continuous contention.
        arb_run(0, 4);
        arb_run(1, 4);
        do_txn(1, 1'b0, 1'b1, 1'b0, 8'h04, 8'h00, -1);
        do_txn(1, 1'b0, 1'b1, 1'b1, 8'h55, 8'hAA, -1);

        // Reset during the strobe of a write, then normal service.
        do_txn(0, 1'b0, 1'b0, 1'b1, 8'h33, 8'h99, SETUP_OF[0] + 1);
        do_txn(0, 1'b1, 1'b1, 1'b1, 8'h44, 8'h66, -1);
        do_txn(0, 1'b0, 1'b0, 1'b0, 8'h04, 8'h00, -1);

        // Random traffic across all instances.
        for (int i = 0; i < 30; i++) begin
            do_txn($urandom_range(0, NI - 1), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
